// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Imported by the interface, the picker and the arbiter top.
package mem_arb_pkg;

    localparam int N_REQ      = 2;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             req_we;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]            rdata;
    logic [ADDR_W-1:0]            mem_address;
    logic [DATA_W-1:0]            mem_data_out;
    logic                         mem_we;
    logic [DATA_W-1:0]            mem_data_in;

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        input  mem_data_in,
        output gnt, rvalid, rdata,
        output mem_address, mem_data_out, mem_we
    );

    modport master (
        output req, req_we, req_addr, req_wdata,
        output mem_data_in,
        input  gnt, rvalid, rdata,
        input  mem_address, mem_data_out, mem_we
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin choice between two requesters.
// On a tie the requester that did not win last time goes.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic             valid,
    output logic             idx
);

    always_comb begin
        valid = |req;
        idx   = 1'b0;
        case (req)
            2'b11:   idx = ~last;
            2'b10:   idx = 1'b1;
            default: idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one synchronous-read memory.
// Fixed IDLE -> ACCESS -> RESP cycle; all outputs registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_t state, state_n;

    logic              last_q, last_n;
    logic              sel_q, sel_n;
    logic              wr_q, wr_n;
    logic [N_REQ-1:0]  gnt_q, gnt_n;
    logic [N_REQ-1:0]  rvalid_q, rvalid_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] dout_q, dout_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              we_q, we_n;
    logic              pick_valid;
    logic              pick_idx;

    rr_pick u_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n  = state;
        last_n   = last_q;
        sel_n    = sel_q;
        wr_n     = wr_q;
        gnt_n    = '0;
        rvalid_n = '0;
        we_n     = 1'b0;
        dout_n   = '0;
        addr_n   = addr_q;
        rdata_n  = rdata_q;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = ACCESS;
                    last_n  = pick_idx;
                    sel_n   = pick_idx;
                    wr_n    = bus.req_we[pick_idx];
                    gnt_n   = onehot(pick_idx);
                    we_n    = bus.req_we[pick_idx];
                    addr_n  = bus.req_addr[pick_idx];
                    if (bus.req_we[pick_idx])
                        dout_n = bus.req_wdata[pick_idx];
                end
            end
            ACCESS: begin
                state_n = RESP;
            end
            RESP: begin
                state_n  = IDLE;
                rvalid_n = onehot(sel_q);
                // memory returns data one cycle after the address
                if (!wr_q)
                    rdata_n = bus.mem_data_in;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_n;
            last_q   <= last_n;
            sel_q    <= sel_n;
            wr_q     <= wr_n;
            gnt_q    <= gnt_n;
            rvalid_q <= rvalid_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            dout_q   <= dout_n;
            rdata_q  <= rdata_n;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.rdata        = rdata_q;
    assign bus.mem_address  = addr_q;
    assign bus.mem_data_out = dout_q;
    assign bus.mem_we       = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, corner sequences and
// random traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EQ = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // memory with a synchronous read port
    logic [DW-1:0] mem [256];
    bit            wv  [256];

    function automatic logic [31:0] dflt(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5a, 8'hc3};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_address[7:0]] <= bus.mem_data_out;
            wv[bus.mem_address[7:0]]  <= 1'b1;
        end
        bus.mem_data_in <= wv[bus.mem_address[7:0]] ?
            mem[bus.mem_address[7:0]] : dflt(bus.mem_address[7:0]);
    end

    int vec  = 0;
    int miss = 0;

    // reference model: per-cycle expected outputs
    logic [1:0]  e_gnt  [EQ];
    logic [1:0]  e_rv   [EQ];
    logic        e_we   [EQ];
    logic [31:0] e_dout [EQ];
    logic [31:0] e_addr [EQ];
    logic [31:0] e_rd   [EQ];
    bit          e_as   [EQ];
    bit          e_rs   [EQ];
    logic [31:0] rmem   [256];
    bit          rwv    [256];
    int          cyc  = 0;
    int          busy = 0;
    bit          model_on = 0;
    logic        ptr = 1'b1;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: actual %h required %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic clr(input int i);
        e_gnt[i] = '0; e_rv[i] = '0; e_we[i] = 1'b0;
        e_dout[i] = '0; e_addr[i] = '0; e_rd[i] = '0;
        e_as[i] = 0; e_rs[i] = 0;
    endtask

    task automatic model_sample();
        int n, k, i;
        logic [7:0] a;
        cyc++;
        n = cyc;
        if (reset) begin
            for (int j = 1; j <= 3; j++) clr((n + j) % EQ);
            i = (n + 1) % EQ;
            e_as[i] = 1; e_addr[i] = '0;
            e_rs[i] = 1; e_rd[i] = '0;
            ptr = 1'b1;
            busy = n + 1;
            model_on = 1;
        end else if (model_on && n >= busy && bus.req != 2'b00) begin
            if (bus.req == 2'b11) k = ptr ? 0 : 1;
            else k = bus.req[1] ? 1 : 0;
            ptr = (k == 1);
            busy = n + 3;
            i = (n + 1) % EQ;
            e_gnt[i] = (k == 1) ? 2'b10 : 2'b01;
            e_we[i] = bus.req_we[k];
            e_as[i] = 1;
            e_addr[i] = bus.req_addr[k];
            e_dout[i] = bus.req_we[k] ? bus.req_wdata[k] : 32'h0;
            a = bus.req_addr[k][7:0];
            i = (n + 3) % EQ;
            e_rv[i] = (k == 1) ? 2'b10 : 2'b01;
            if (bus.req_we[k]) begin
                rmem[a] = bus.req_wdata[k];
                rwv[a] = 1;
            end else begin
                e_rs[i] = 1;
                e_rd[i] = rwv[a] ? rmem[a] : dflt(a);
            end
        end
    endtask

    task automatic model_check();
        int i;
        i = (cyc + 1) % EQ;
        if (!model_on) return;
        if (e_as[i]) cur_addr = e_addr[i];
        if (e_rs[i]) cur_rd = e_rd[i];
        chk("gnt", 32'(bus.gnt), 32'(e_gnt[i]));
        chk("rvalid", 32'(bus.rvalid), 32'(e_rv[i]));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we[i]));
        chk("mem_address", bus.mem_address, cur_addr);
        chk("mem_data_out", bus.mem_data_out, e_dout[i]);
        chk("rdata", bus.rdata, cur_rd);
        clr(i);
    endtask

    task automatic tick();
        @(posedge clk);
        model_sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic drive(input int id, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req[id]       = 1'b1;
        bus.req_we[id]    = we;
        bus.req_addr[id]  = a;
        bus.req_wdata[id] = d;
    endtask

    task automatic flush(input int n);
        bus.req = 2'b00;
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } tv_t;

    tv_t tv [6];
    bit  pend [2];

    initial begin
        logic [1:0]  eg;
        logic [31:0] a;
        int          gc [4];
        int          gi [4];
        int          ng;
        bit          saw;

        for (int i = 0; i < EQ; i++) clr(i);
        bus.req = '0; bus.req_we = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        tv[0] = '{0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
        tv[1] = '{1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF};
        tv[2] = '{0, 1'b0, 32'h20, 32'h0, 32'h12345678};
        tv[3] = '{1, 1'b0, 32'h33, 32'h0, 32'h33CC69C3};
        tv[4] = '{0, 1'b1, 32'h33, 32'hA5A50001, 32'h33CC69C3};
        tv[5] = '{1, 1'b0, 32'h33, 32'h0, 32'hA5A50001};

        do_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);

        for (int v = 0; v < 6; v++) begin
            drive(tv[v].id, tv[v].we, tv[v].addr, tv[v].wdata);
            tick();
            eg = (tv[v].id == 1) ? 2'b10 : 2'b01;
            chk("tv_gnt", 32'(bus.gnt), 32'(eg));
            chk("tv_we", 32'(bus.mem_we), 32'(tv[v].we));
            chk("tv_addr", bus.mem_address, tv[v].addr);
            chk("tv_dout", bus.mem_data_out,
                tv[v].we ? tv[v].wdata : 32'h0);
            bus.req = 2'b00;
            tick();
            chk("tv_resp_we", 32'(bus.mem_we), 32'h0);
            chk("tv_resp_addr", bus.mem_address, tv[v].addr);
            tick();
            chk("tv_rvalid", 32'(bus.rvalid), 32'(eg));
            chk("tv_rdata", bus.rdata, tv[v].rd);
            tick();
            chk("tv_rv_off", 32'(bus.rvalid), 32'h0);
        end

        // isolation: requester 1 payload churns during a read
        drive(0, 1'b0, 32'h10, 32'h0);
        bus.req[1] = 1'b0;
        tick();
        bus.req[0] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            chk("iso_addr", bus.mem_address, 32'h10);
            bus.req_addr[1] = $urandom;
            bus.req_we[1] = 1'b1;
            tick();
        end
        chk("iso_rvalid", 32'(bus.rvalid), 32'h1);
        chk("iso_rdata", bus.rdata, 32'hDEADBEEF);

        // back-to-back from the rvalid cycle
        drive(0, 1'b0, 32'h20, 32'h0);
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        chk("b2b_rvalid", 32'(bus.rvalid), 32'h1);
        drive(0, 1'b0, 32'h33, 32'h0);
        tick();
        chk("b2b_gnt", 32'(bus.gnt), 32'h1);
        flush(3);
        chk("b2b_rdata", bus.rdata, 32'hA5A50001);

        // contention right after reset
        do_reset();
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h20, 32'h0);
        ng = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus.gnt != 2'b00 && ng < 4) begin
                gc[ng] = cyc;
                gi[ng] = bus.gnt[1] ? 1 : 0;
                ng++;
            end
        end
        chk("cont_count", 32'(ng), 32'd4);
        for (int j = 0; j < ng; j++) begin
            chk("cont_order", 32'(gi[j]), 32'(j % 2));
            if (j > 0) chk("cont_gap", 32'(gc[j] - gc[j-1]), 32'd3);
        end
        flush(3);

        // reset lands on the access cycle of a write
        drive(1, 1'b1, 32'h40, 32'hCAFE0040);
        tick();
        chk("rmw_we_access", 32'(bus.mem_we), 32'h1);
        reset = 1'b1;
        bus.req = 2'b00;
        tick();
        chk("rmw_we_after", 32'(bus.mem_we), 32'h0);
        reset = 1'b0;
        saw = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (bus.rvalid != 2'b00) saw = 1;
        end
        chk("rmw_no_rvalid", 32'(saw), 32'h0);
        drive(0, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b0, 32'h41, 32'h0);
        tick();
        chk("rmw_tie_gnt", 32'(bus.gnt), 32'h1);
        flush(3);
        chk("rmw_rdata", bus.rdata, 32'hCAFE0040);

        // random traffic
        pend[0] = 0;
        pend[1] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.gnt[i]) pend[i] = 0;
                if (!pend[i]) begin
                    a = $urandom;
                    a[7:4] = 4'h0;
                    bus.req_addr[i] = a;
                    bus.req_wdata[i] = $urandom;
                    bus.req_we[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1;
                        bus.req[i] = 1'b1;
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
            reset = ($urandom_range(0, 149) == 0);
            tick();
            chk("one_hot_gnt", 32'($countones(bus.gnt) <= 1), 32'h1);
            chk("one_hot_rv", 32'($countones(bus.rvalid) <= 1), 32'h1);
        end
        reset = 1'b0;
        flush(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
